// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared sizing, drain length and drain FSM states for the systolic array input controller
package sys_arr_pkg;

    // Array dimension (number of row FIFOs) and element width
    localparam int N  = 4;
    localparam int DW = 8;

    // A skewed drain of one N x N matrix spans 2N-1 cycles
    localparam int DRAIN_LEN = 2 * N - 1;

    // Counter widths: drain step counter and row load counter
    localparam int TW = $clog2(DRAIN_LEN);
    localparam int RW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sysarr_skew_gen.sv
// sysarr_skew_gen: diagonal skew decode, row r shifts while r <= t <= r+N-1 during a drain
module sysarr_skew_gen
    import sys_arr_pkg::*;
(
    input  logic          active,
    input  logic [TW-1:0] t,
    output logic [N-1:0]  shift
);

    // t - r wraps to a value >= N whenever t < r, because 2^TW >= 2N-1,
    // so a single unsigned compare covers both window bounds.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [TW-1:0] d;
        assign d        = t - TW'(r);
        assign shift[r] = active && (d < TW'(N));
    end

endmodule

// File: rtl/sysarr_fifo_ctrl.sv
// sysarr_fifo_ctrl: loads matrix rows into N row FIFOs and drains buffered matrices into the array with diagonal skew
module sysarr_fifo_ctrl
    import sys_arr_pkg::*;
(
    input  logic            clk,
    input  logic            nRST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_data,
    input  logic            arr_ready,
    output logic [N-1:0]    fifo_load,
    output logic [DW*N-1:0] fifo_load_values,
    output logic [N-1:0]    fifo_shift,
    output logic            drain_done,
    output logic            busy
);

    drain_state_t  state;
    logic [TW-1:0] t;
    logic [RW-1:0] ld_row;
    logic [1:0]    full_cnt;
    logic          draining;
    logic          last_t;
    logic          xfer;
    logic          wrap;
    logic          start;
    logic [2:0]    committed;

    // Handshake, slot accounting and drain-start decision; start only looks at
    // matrices already complete, so a row finishing this cycle waits for a later one
    always_comb begin
        draining  = state == DRAIN;
        last_t    = draining && t == TW'(DRAIN_LEN - 1);
        committed = {1'b0, full_cnt} + {2'b0, draining};
        in_ready  = ld_row != '0 || committed < 3'd2;
        xfer      = in_valid && in_ready;
        wrap      = xfer && ld_row == RW'(N - 1);
        start     = full_cnt != 2'd0 && arr_ready && (!draining || last_t);
        fifo_load = xfer ? N'(1) << ld_row : '0;
        busy      = draining || full_cnt != 2'd0 || ld_row != '0;
    end

    assign fifo_load_values = in_data;

    // Drain FSM: t walks 0..2N-2, re-entering DRAIN directly when another matrix is ready
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            t          <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= draining && t == TW'(DRAIN_LEN - 2);
            if (start) begin
                state <= DRAIN;
                t     <= '0;
            end else if (last_t) begin
                state <= IDLE;
                t     <= '0;
            end else if (draining) begin
                t <= t + TW'(1);
            end
        end
    end

    // Row counter and count of complete matrices waiting; a simultaneous wrap and start cancel
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ld_row   <= '0;
            full_cnt <= 2'd0;
        end else begin
            if (xfer)
                ld_row <= wrap ? '0 : ld_row + RW'(1);
            full_cnt <= full_cnt + {1'b0, wrap} - {1'b0, start};
        end
    end

    sysarr_skew_gen u_skew (
        .active (draining),
        .t      (t),
        .shift  (fifo_shift)
    );

endmodule

// File: tb/tb_sysarr_fifo_ctrl.sv
// tb_sysarr_fifo_ctrl: directed and random stimulus against a schedule-based reference model
module tb_sysarr_fifo_ctrl;
    import sys_arr_pkg::*;

    localparam int W = DW * N;
    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         nRST = 1'b0;
    logic         in_valid = 1'b0;
    logic         arr_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [N-1:0] fifo_load;
    logic [W-1:0] fifo_load_values;
    logic [N-1:0] fifo_shift;
    logic         drain_done;
    logic         busy;

    int nchk = 0;
    int npass = 0;

    // Reference model: rows of the matrix being loaded, complete matrices waiting,
    // last cycle of the current drain, and a per-cycle schedule of expected strobes
    int cyc;
    int rows;
    int full;
    int drain_until;
    logic [N-1:0] exp_shift [0:DEPTH-1];
    logic         exp_done  [0:DEPTH-1];

    always #5 clk = ~clk;

    sysarr_fifo_ctrl dut (
        .clk              (clk),
        .nRST             (nRST),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .arr_ready        (arr_ready),
        .fifo_load        (fifo_load),
        .fifo_load_values (fifo_load_values),
        .fifo_shift       (fifo_shift),
        .drain_done       (drain_done),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0;
        rows = 0;
        full = 0;
        drain_until = -1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_shift[i] = '0;
            exp_done[i]  = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance the model
    task automatic tick(input logic v, input logic ar);
        logic         er;
        logic [N-1:0] el;
        logic         dr;
        in_valid  = v;
        arr_ready = ar;
        in_data   = W'($urandom);
        #1;
        dr = cyc <= drain_until;
        er = rows != 0 || (full + int'(dr)) < 2;
        el = (v && er) ? N'(1) << rows : '0;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("fifo_load", 64'(fifo_load), 64'(el));
        chk("load_values", 64'(fifo_load_values), 64'(in_data));
        chk("fifo_shift", 64'(fifo_shift), 64'(exp_shift[cyc]));
        chk("drain_done", 64'(drain_done), 64'(exp_done[cyc]));
        chk("busy", 64'(busy), 64'(dr || full > 0 || rows > 0));
        if (full > 0 && ar && cyc >= drain_until) begin
            full--;
            drain_until = cyc + 2 * N - 1;
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++)
                    exp_shift[cyc + 1 + r + j][r] = 1'b1;
            exp_done[cyc + 2 * N - 1] = 1'b1;
        end
        if (v && er) begin
            rows++;
            if (rows == N) begin
                rows = 0;
                full++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_fifo_load"}, 64'(fifo_load), 64'(0));
        chk({tag, "_fifo_shift"}, 64'(fifo_shift), 64'(0));
        chk({tag, "_drain_done"}, 64'(drain_done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_full_cnt"}, 64'(dut.full_cnt), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b0;
        in_valid = 1'b0;
        arr_ready = 1'b0;
        check_reset_outputs("reset");
        @(negedge clk);
        nRST = 1'b1;
        model_reset();
    endtask

    // Single matrix: four consecutive rows, one-cycle arr_ready, then let it drain out
    task automatic load_and_drain();
        for (int i = 0; i < N; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 2 * N + 2; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        check_reset_outputs("por");
        @(negedge clk);
        nRST = 1'b1;

        // Single load and drain
        load_and_drain();

        // Two matrices buffered fill both slots; a ninth row is refused
        do_reset();
        for (int i = 0; i < 2 * N; i++) tick(1'b1, 1'b0);
        chk("two_full", 64'(dut.full_cnt), 64'(2));
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        // Back-to-back drains with arr_ready held high
        for (int i = 0; i < 4 * N; i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Last row of matrix 2 lands in the same cycle matrix 1 starts draining
        do_reset();
        for (int i = 0; i < 2 * N - 1; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("net_full_cnt", 64'(dut.full_cnt), 64'(1));
        for (int i = 0; i < 4 * N; i++) tick(1'b0, 1'b1);

        // Reset at t=3 of a drain, then a full repeat of the single-matrix run
        do_reset();
        for (int i = 0; i < N; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        nRST = 1'b0;
        check_reset_outputs("mid_drain");
        @(negedge clk);
        nRST = 1'b1;
        model_reset();
        load_and_drain();

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
